simon_cipher_core: RTL and testbench
====================================

// Module: simon_cipher_core
// PURPOSE
//  Downstream consumer of the 13-byte UART frame assembler: takes its 104-bit frame plus start pulse,
//  runs SIMON 32/64 (16-bit words, 4-word key) encrypt or decrypt, presents 32-bit result + done pulse.
//  Iterative: one key-schedule word per cycle, then one round per cycle; feeds the UART transmit path.
// PARAMETERS
//  ROUNDS        32     rounds executed; legal 4..32; 32 = standard SIMON 32/64
//  DECRYPT_CODE  8'h44  mode byte ('D') selecting decrypt; any other mode byte = encrypt
// PORTS
//  clk           in   1    single system clock, all logic on rising edge
//  rst           in   1    synchronous, active-low reset
//  start_cipher  in   1    1-cycle pulse: data valid, begin operation
//  data          in   104  [103:96] mode, [95:80] x, [79:64] y, [63:48] k3 .. [15:0] k0
//  busy          out  1    high from capture edge until done cycle inclusive
//  done          out  1    1-cycle pulse, result valid
//  result        out  32   {x,y} after last round; held until next capture
// BEHAVIOUR
//  - Reset (rst==0 at edge): state IDLE, busy=0, done=0, result=0, round-key file + counters cleared.
//    Reset mid-operation aborts it; no done pulse follows.
//  - FSM IDLE -> EXPAND -> ROUND -> IDLE.
//    IDLE: start_cipher=1 latches mode,x,y, k[0..3]=key words; busy<=1; -> EXPAND.
//    EXPAND: per cycle i=0..ROUNDS-5: t=ROR3(k[i+3])^k[i+1]; t=t^ROR1(t);
//      k[i+4]=~k[i]^t^z0[i]^16'h0003 (z0 = 62-bit SIMON sequence, bit0 first:
//      11111010001001010110000111001101111101000100101011000011100110). Last -> ROUND.
//    ROUND: counter r=0..ROUNDS-1, f(w)=(ROL1(w)&ROL8(w))^ROL2(w).
//      encrypt: {x,y} <= {y^f(x)^k[r], x}; decrypt: {x,y} <= {y, x^f(y)^k[ROUNDS-1-r]}.
//      Final round: result<={x,y} (new values), done<=1, -> IDLE.
//  - Latency (ROUNDS=32): done high in the cycle after the 60th rising edge following the capture edge
//    (28 expand + 32 round); busy drops with done's fall; next start accepted the cycle done is high.
//  - start_cipher while busy (except the done cycle) is ignored; data changes while busy ignored.
//  - All arithmetic 16-bit, rotations modulo 16; no carries. Mode compared on full 8 bits.
// CONFIGURATION
//  SIMON_KEY_CACHE_EN defined: on capture, if cache valid and data[63:0] equals the cached key,
//    skip EXPAND (IDLE -> ROUND, latency 32 edges). Cache valid set on EXPAND completion, cleared by
//    reset or by reset mid-EXPAND. Key compare and register add one 64-bit register.
//  Undefined: always EXPAND; latency fixed at 60; no cache storage.
// TESTING
//  1 Encrypt vector: data={8'h45,32'h65656877,64'h1918111009080100}, pulse -> done after 60 edges,
//    result=32'hc69be9bb, busy high throughout.
//  2 Decrypt: data={8'h44,32'hc69be9bb,64'h1918111009080100} -> result=32'h65656877.
//  3 Second start pulse 10 cycles into op with different data -> ignored; result still 32'hc69be9bb.
//  4 rst=0 for 1 cycle at cycle 30 of test 1 -> busy=0,result=0, no done; new start runs normally.
//  5 Back-to-back: start in done cycle -> accepted; both results correct, no lost pulse.
//  6 SIMON_KEY_CACHE_EN: repeat test 1 twice -> 2nd done after 32 edges, same result;
//    change key -> 60 edges again.

Source files
------------

// File: rtl/simon_cipher_core.sv
`default_nettype none
// ============================================================================
// Module   : simon_cipher_core
// Purpose  : Iterative SIMON 32/64 encrypt/decrypt: key expansion, then one round per cycle.
// Config   : SIMON_KEY_CACHE_EN enables reuse of an already-expanded key.
// Revision : 1.0  initial release
// ============================================================================
module simon_cipher_core #(
  parameter int          ROUNDS       = 32,
  parameter logic [7:0]  DECRYPT_CODE = 8'h44
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_cipher,
  input  logic [103:0]  data,
  output logic          busy,
  output logic          done,
  output logic [31:0]   result
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_ROUND  = 2'd2;

  localparam logic [4:0] c_EXP_LAST    = 5'(ROUNDS - 5);
  localparam logic [4:0] c_RND_LAST    = 5'(ROUNDS - 1);
  localparam logic       c_SKIP_EXPAND = 1'(ROUNDS == 4);
  // z0 sequence, bit i is the constant used for expanded key word i+4
  localparam logic [61:0] c_Z0 =
    62'b01100111000011010100100010111110110011100001101010010001011111;

  logic [1:0]  state_q, state_d;
  logic [4:0]  idx_q;
  logic [15:0] x_q, y_q;
  logic        dec_q;
  logic [15:0] k_q [0:ROUNDS-1];
  logic        busy_q, done_q;
  logic [31:0] result_q;

  logic        capture, expand_en, round_en, exp_last, rnd_last, cache_hit;
  logic [15:0] t0, t1, k_new, rk, x_nxt, y_nxt;
  logic [4:0]  rk_idx;

  function automatic logic [15:0] f_rnd(input logic [15:0] w);
    f_rnd = ({w[14:0], w[15]} & {w[7:0], w[15:8]}) ^ {w[13:0], w[15:14]};
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_cipher) state_d = (c_SKIP_EXPAND || cache_hit) ? S_ROUND : S_EXPAND;
      end
      S_EXPAND: if (exp_last) state_d = S_ROUND;
      S_ROUND:  if (rnd_last) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    capture   = 1'b0;
    expand_en = 1'b0;
    round_en  = 1'b0;
    exp_last  = 1'b0;
    rnd_last  = 1'b0;
    case (state_q)
      S_IDLE:   capture = start_cipher;
      S_EXPAND: begin
        expand_en = 1'b1;
        exp_last  = (idx_q == c_EXP_LAST);
      end
      S_ROUND: begin
        round_en = 1'b1;
        rnd_last = (idx_q == c_RND_LAST);
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    t0    = {k_q[idx_q + 5'd3][2:0], k_q[idx_q + 5'd3][15:3]} ^ k_q[idx_q + 5'd1];
    t1    = t0 ^ {t0[0], t0[15:1]};
    k_new = ~k_q[idx_q] ^ t1 ^ {15'd0, c_Z0[idx_q]} ^ 16'h0003;
    rk_idx = dec_q ? (c_RND_LAST - idx_q) : idx_q;
    rk     = k_q[rk_idx];
    if (dec_q) begin
      x_nxt = y_q;
      y_nxt = x_q ^ f_rnd(y_q) ^ rk;
    end else begin
      x_nxt = y_q ^ f_rnd(x_q) ^ rk;
      y_nxt = x_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q    <= 5'd0;
      x_q      <= 16'd0;
      y_q      <= 16'd0;
      dec_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
      for (int i = 0; i < ROUNDS; i++) k_q[i] <= 16'd0;
    end else begin
      done_q <= rnd_last;
      if (capture) begin
        busy_q <= 1'b1;
        idx_q  <= 5'd0;
        dec_q  <= (data[103:96] == DECRYPT_CODE);
        x_q    <= data[95:80];
        y_q    <= data[79:64];
        k_q[3] <= data[63:48];
        k_q[2] <= data[47:32];
        k_q[1] <= data[31:16];
        k_q[0] <= data[15:0];
      end else if (state_q == S_IDLE) begin
        busy_q <= 1'b0;
      end
      if (expand_en) begin
        k_q[idx_q + 5'd4] <= k_new;
        idx_q <= exp_last ? 5'd0 : idx_q + 5'd1;
      end
      if (round_en) begin
        x_q   <= x_nxt;
        y_q   <= y_nxt;
        idx_q <= idx_q + 5'd1;
        if (rnd_last) result_q <= {x_nxt, y_nxt};
      end
    end
  end

`ifdef SIMON_KEY_CACHE_EN
  logic [63:0] cache_key_q;
  logic        cache_valid_q;

  assign cache_hit = cache_valid_q && (data[63:0] == cache_key_q);

  // The key file still holds the expanded schedule of the cached key on a hit
  always_ff @(posedge clk) begin
    if (!rst) begin
      cache_key_q   <= 64'd0;
      cache_valid_q <= 1'b0;
    end else if (capture && !cache_hit) begin
      cache_key_q   <= data[63:0];
      cache_valid_q <= 1'b0;
    end else if (exp_last) begin
      cache_valid_q <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_simon_cipher_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_simon_cipher_core
// Purpose  : Directed-vector bench for simon_cipher_core (SIMON 32/64 reference vectors).
// Revision : 1.0  initial release
// ============================================================================
module tb_simon_cipher_core;

  localparam logic [103:0] c_ENC = {8'h45, 32'h65656877, 64'h1918111009080100};
  localparam logic [103:0] c_DEC = {8'h44, 32'hc69be9bb, 64'h1918111009080100};
  localparam logic [103:0] c_ENC_M = {8'hC4, 32'h65656877, 64'h1918111009080100};
  localparam logic [103:0] c_OTHER = {8'h44, 32'h12345678, 64'hdeadbeef01234567};
`ifdef SIMON_KEY_CACHE_EN
  localparam int c_LAT_REPEAT = 32;
`else
  localparam int c_LAT_REPEAT = 60;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start_cipher = 1'b0;
  logic [103:0] data = '0;
  logic         busy, done;
  logic [31:0]  result;

  int n_checks = 0;
  int n_errors = 0;

  simon_cipher_core dut (
    .clk          (clk),
    .rst          (rst),
    .start_cipher (start_cipher),
    .data         (data),
    .busy         (busy),
    .done         (done),
    .result       (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Leaves time at capture edge + 1
  task automatic pulse(input logic [103:0] d);
    start_cipher = 1'b1;
    data         = d;
    @(posedge clk); #1;
    start_cipher = 1'b0;
  endtask

  task automatic wait_done(input int e0, output int edges, output logic busy_ok);
    edges   = e0;
    busy_ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      edges++;
      if (!busy) busy_ok = 1'b0;
      if (done) break;
    end
  endtask

  initial begin
    int   edges;
    logic bok;
    logic seen_done;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: encrypt reference vector
    pulse(c_ENC);
    check("t1_busy_cap", {31'd0, busy}, 32'd1);
    wait_done(0, edges, bok);
    check("t1_latency", 32'(edges), 32'd60);
    check("t1_result", result, 32'hc69be9bb);
    check("t1_busy_thru", {31'd0, bok}, 32'd1);
    @(posedge clk); #1;
    check("t1_done_pulse", {31'd0, done}, 32'd0);
    check("t1_busy_drop", {31'd0, busy}, 32'd0);
    check("t1_result_held", result, 32'hc69be9bb);

    // 2: decrypt
    do_reset();
    pulse(c_DEC);
    wait_done(0, edges, bok);
    check("t2_latency", 32'(edges), 32'd60);
    check("t2_result", result, 32'h65656877);

    // Mode byte differing only in bit 7 must still encrypt
    do_reset();
    pulse(c_ENC_M);
    wait_done(0, edges, bok);
    check("mode_full8_result", result, 32'hc69be9bb);

    // 3: start while busy is ignored
    do_reset();
    pulse(c_ENC);
    repeat (10) @(posedge clk);
    #1;
    pulse(c_OTHER);
    wait_done(11, edges, bok);
    check("t3_latency", 32'(edges), 32'd60);
    check("t3_result", result, 32'hc69be9bb);

    // 4: reset mid-operation aborts without done
    do_reset();
    pulse(c_ENC);
    seen_done = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_result", result, 32'd0);
    check("t4_done", {31'd0, done}, 32'd0);
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1'b1;
    end
    check("t4_no_done", {31'd0, seen_done}, 32'd0);
    pulse(c_ENC);
    wait_done(0, edges, bok);
    check("t4_rerun_latency", 32'(edges), 32'd60);
    check("t4_rerun_result", result, 32'hc69be9bb);

    // 5: back-to-back, second start in the done cycle
    do_reset();
    pulse(c_ENC);
    wait_done(0, edges, bok);
    check("t5a_latency", 32'(edges), 32'd60);
    check("t5a_result", result, 32'hc69be9bb);
    pulse(c_DEC);
    check("t5_busy_kept", {31'd0, busy}, 32'd1);
    check("t5_done_fell", {31'd0, done}, 32'd0);
    wait_done(0, edges, bok);
    check("t5b_latency", 32'(edges), 32'(c_LAT_REPEAT));
    check("t5b_result", result, 32'h65656877);
    check("t5b_busy_thru", {31'd0, bok}, 32'd1);

`ifdef SIMON_KEY_CACHE_EN
    // 6: cached key skips expansion; a new key expands again
    do_reset();
    pulse(c_ENC);
    wait_done(0, edges, bok);
    check("t6a_latency", 32'(edges), 32'd60);
    @(posedge clk); #1;
    pulse(c_ENC);
    wait_done(0, edges, bok);
    check("t6b_latency", 32'(edges), 32'd32);
    check("t6b_result", result, 32'hc69be9bb);
    @(posedge clk); #1;
    pulse(c_OTHER);
    wait_done(0, edges, bok);
    check("t6c_latency", 32'(edges), 32'd60);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
